// File: rtl/sipo_deframer.sv
// -----------------------------------------------------------------------------
// sipo_deframer
//
// Serial-in / parallel-out deframer. Bits arrive MSB first on serial_in and
// are sampled on rising clk while serial_valid is 1. Every N sampled bits
// form a word. The word is presented on parallel_out with a valid/ready
// handshake.
//
// If a word completes while the previous word is still unconsumed, the new
// word is dropped and overrun pulses for one cycle. The sync input discards
// any partial word and restarts bit counting.
//
// Optional feature, macro SIPO_DEFRAMER_PARITY_EN:
//   When this macro is defined, each frame is N data bits followed by one
//   even-parity bit. parity_err is loaded together with parallel_out.
//   When it is undefined, parity_err is tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   sync         in   word-alignment strobe (clears bit counter)
//   serial_in    in   serial data bit, MSB first
//   serial_valid in   qualifies serial_in
//   out_ready    in   consumer accepts parallel_out when out_valid=1
//   parallel_out out  last completed word [N-1:0]
//   out_valid    out  parallel_out holds an unconsumed word
//   overrun      out  one-cycle pulse when a completed word is dropped
//   parity_err   out  parity status of the word on parallel_out
// -----------------------------------------------------------------------------
module sipo_deframer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sync,
    input  logic         serial_in,
    input  logic         serial_valid,
    input  logic         out_ready,
    output logic [N-1:0] parallel_out,
    output logic         out_valid,
    output logic         overrun,
    output logic         parity_err
);

`ifdef SIPO_DEFRAMER_PARITY_EN
    // The counter goes one step further because the parity bit follows the data.
    localparam int TERM = N;
`else
    localparam int TERM = N - 1;
`endif
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_TERM = CW'(TERM);

    logic [N-1:0]  r_shreg;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_out;
    logic          r_valid;
    logic          r_overrun;

    logic          w_sample;
    logic          w_last;
    logic          w_shift;
    logic [N-1:0]  w_word;

    // sync takes priority: while it is high, the serial bit is ignored.
    assign w_sample = serial_valid && !sync;
    assign w_last   = w_sample && (r_cnt == CNT_TERM);

`ifdef SIPO_DEFRAMER_PARITY_EN
    logic r_perr;
    logic w_perr;

    // The final bit is the parity bit. It is not shifted in, so shreg keeps
    // the data word intact.
    assign w_shift = w_sample && !w_last;
    assign w_word  = r_shreg;
    assign w_perr  = (^r_shreg) ^ serial_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else if (w_last && (!r_valid || out_ready)) begin
            r_perr <= w_perr;
        end
    end

    assign parity_err = r_perr;
`else
    assign w_shift    = w_sample;
    assign w_word     = {r_shreg[N-2:0], serial_in};
    assign parity_err = 1'b0;
`endif

    // Shift register and bit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_shift) begin
                r_shreg <= {r_shreg[N-2:0], serial_in};
            end
            if (sync || w_last) begin
                r_cnt <= '0;
            end else if (w_sample) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Output register, valid flag and overrun pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_last) begin
                if (!r_valid || out_ready) begin
                    // The previous word is consumed on the same edge, so the
                    // new word replaces it and out_valid stays high.
                    r_out   <= w_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign parallel_out = r_out;
    assign out_valid    = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_sipo_deframer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deframer
//
// Directed testbench for sipo_deframer with N=4.
// Each word the stimulus expects to be delivered is pushed into a scoreboard
// queue. The entry is popped and compared when the DUT presents the word.
// -----------------------------------------------------------------------------
module tb_sipo_deframer;
    localparam int N = 4;
`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         sync;
    logic         serial_in;
    logic         serial_valid;
    logic         out_ready;
    logic [N-1:0] parallel_out;
    logic         out_valid;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Scoreboard entries are {parity_err, word}.
    logic [N:0] sb_q[$];

    sipo_deframer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .sync        (sync),
        .serial_in   (serial_in),
        .serial_valid(serial_valid),
        .out_ready   (out_ready),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        tick();
        serial_valid = 1'b0;
    endtask

    // Sends one frame, MSB first.
    //   gap        : insert an idle cycle before every bit.
    //   ready_last : value driven on out_ready for the completing bit.
    //   flip       : invert the parity bit (parity build only).
    //   deliver    : push the expected word into the scoreboard.
    //   chk_idle   : on gap cycles, check that no word has completed yet.
    task automatic send_word(input logic [N-1:0] w, input bit gap, input bit ready_last,
                             input bit flip, input bit deliver, input bit chk_idle);
        for (int i = N - 1; i >= 0; i--) begin
            if (gap) begin
                tick();
                if (chk_idle) chk("gap_no_complete", 32'(out_valid), 32'd0);
            end
            if (!PAR && i == 0) out_ready = ready_last;
            send_bit(w[i]);
        end
`ifdef SIPO_DEFRAMER_PARITY_EN
        if (gap) tick();
        out_ready = ready_last;
        send_bit((^w) ^ flip);
`endif
        if (deliver) sb_q.push_back({(PAR ? flip : 1'b0), w});
    endtask

    task automatic check_word(input string tag);
        logic [N:0] e;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sb_has_entry"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_data"}, 32'(parallel_out), 32'(e[N-1:0]));
            chk({tag, "_perr"}, 32'(parity_err), 32'(e[N]));
        end
    endtask

    initial begin
        reset        = 1'b1;
        sync         = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        out_ready    = 1'b0;
        #2 reset = 1'b0;
        #10;
        chk("rst_data", 32'(parallel_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        #9 reset = 1'b1;
        tick();

        // Basic word with the consumer always ready
        out_ready = 1'b1;
        send_word(4'b1011, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_word("w1011");
        chk("w1011_no_overrun", 32'(overrun), 32'd0);
        tick();
        chk("w1011_valid_clear", 32'(out_valid), 32'd0);

        // Gapped serial_valid: counter must hold during idle cycles
        out_ready = 1'b0;
        send_word(4'b1100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_word("w1100_gapped");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("w1100_consumed", 32'(out_valid), 32'd0);

        // Overrun: hold 1010, then 0110 completes with out_ready=0
        send_word(4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("w1010");
        send_word(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(parallel_out), 32'(4'b1010));
        chk("ovr_valid_kept", 32'(out_valid), 32'd1);
        tick();
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        chk("ovr_data_stable", 32'(parallel_out), 32'(4'b1010));
        chk("ovr_valid_stable", 32'(out_valid), 32'd1);

        // Handshake on the completion edge replaces the word without overrun
        send_word(4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_word("w0110_replace");
        chk("w0110_no_overrun", 32'(overrun), 32'd0);
        tick();
        chk("w0110_valid_clear", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // sync discards the partial word (the sampled bit during sync is ignored)
        send_bit(1'b1);
        send_bit(1'b0);
        sync         = 1'b1;
        serial_in    = 1'b1;
        serial_valid = 1'b1;
        tick();
        sync         = 1'b0;
        serial_valid = 1'b0;
        chk("sync_no_complete", 32'(out_valid), 32'd0);
        send_word(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("w0111_after_sync");

        // Asynchronous reset mid-cycle after 2 bits (word 0111 is still held)
        send_bit(1'b1);
        send_bit(1'b0);
        #3 reset = 1'b0;
        #1;
        chk("arst_data", 32'(parallel_out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_perr", 32'(parity_err), 32'd0);
        #2 reset = 1'b1;
        send_word(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("w1001_after_reset");

`ifdef SIPO_DEFRAMER_PARITY_EN
        // Parity: a good parity bit and then a bad one
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_word(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("par_good");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_word(4'b1011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_word("par_bad");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
SIPO_DEFRAMER -- requirements
Module: sipo_deframer

Interface
REQ-001 Parameter N, default 4: data word width in bits, N >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; the block is in reset while reset is 0.
REQ-004 sync  input  1  synchronous word-alignment strobe; discards partial bits and restarts counting.
REQ-005 serial_in  input  1  serial data bit, MSB first.
REQ-006 serial_valid  input  1  serial_in is sampled on rising clk only while this is 1.
REQ-007 parallel_out  output  N  last completed word.
REQ-008 out_valid  output  1  parallel_out holds an unconsumed word.
REQ-009 out_ready  input  1  consumer accepts the word on a rising clk when out_valid and out_ready are both 1.
REQ-010 overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-011 parity_err  output  1  parity status of the word on parallel_out (see Configuration).

Function
REQ-012 Internal state SHALL be: shift register shreg[N-1:0]; bit counter cnt, 0..N-1, or 0..N when parity is enabled; output register; out_valid flag.
REQ-013 On each rising clk with serial_valid=1 and sync=0, shreg SHALL become {shreg[N-2:0], serial_in} and cnt SHALL increment.
REQ-014 A word SHALL complete on the edge that samples the last bit (cnt at terminal value); cnt SHALL return to 0 on that edge.
REQ-015 On completion with out_valid=0, or with out_valid=1 and out_ready=1: parallel_out SHALL load the assembled word and out_valid SHALL be 1 after that edge (latency: visible 1 cycle after the final bit edge).
REQ-016 On completion with out_valid=1 and out_ready=0: the new word SHALL be dropped, parallel_out SHALL be unchanged, and overrun SHALL pulse 1 for exactly one cycle.
REQ-017 out_valid SHALL clear on the edge where out_ready=1 and no word completes.
REQ-018 out_valid and parallel_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 sync=1 SHALL force cnt to 0 and ignore serial_in that cycle; it SHALL NOT affect parallel_out, out_valid or a same-cycle out_ready handshake.
REQ-020 When serial_valid=0, shreg and cnt SHALL hold; gaps between bits are permitted.
REQ-021 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-022 While reset=0, the following SHALL be 0 immediately, independent of clk: shreg, cnt, parallel_out, out_valid, overrun and parity_err.
REQ-023 Reset asserted mid-word SHALL discard the partial word.
REQ-024 After reset deasserts, the first sampled bit SHALL be treated as a word MSB.

Configuration
REQ-025 Macro SIPO_DEFRAMER_PARITY_EN.
- When defined: each frame is N data bits followed by one even-parity bit, and completion occurs on bit N+1.
- parity_err SHALL be loaded with the XOR of the N data bits and the parity bit at the same time as parallel_out.
- Words with a parity error SHALL still be delivered.
REQ-026 When SIPO_DEFRAMER_PARITY_EN is undefined: frames are N bits, and parity_err SHALL be tied to 0.

Verification (N=4)
REQ-027 Reset, then 1,0,1,1 with serial_valid=1 and out_ready=1 -> after 4th edge out_valid=1 and parallel_out=4'b1011 for one cycle.
REQ-028 Bits 1,1,0,0 with serial_valid gapped (1,0,1,0,...) -> parallel_out=4'b1100, with no change in cnt on gap cycles.
REQ-029 Word 4'b1010 is held (out_ready=0), then word 4'b0110 completes -> overrun pulses 1 cycle and parallel_out stays 4'b1010. A further case: out_ready=1 on the completion edge of 4'b0110 -> parallel_out=4'b0110, out_valid stays 1, overrun=0.
REQ-030 Bits 1,0 then sync=1 then 0,1,1,1 -> parallel_out=4'b0111.
REQ-031 reset=0 asserted asynchronously mid-cycle after 2 bits -> all outputs 0 before the next clk edge. After release, bits 1,0,0,1 -> 4'b1001.
REQ-032 With SIPO_DEFRAMER_PARITY_EN: data 1011 with parity bit 1 -> parity_err=0. Data 1011 with parity bit 0 -> parity_err=1 and parallel_out=4'b1011.
